im_boot_ctrl: RTL

Boot-load and access controller for the byte-addressed instruction memory. After reset it holds the core in reset and streams program bytes from a byte-wide loader port into instruction memory. On the final byte it hands the memory address port to the fetch stage and releases the core. While running it checks fetch addresses and supports reloading the program.

---
 rtl/im_boot_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/im_boot_ctrl.sv
// =====================================================================
// im_boot_ctrl: boot-load and fetch-access controller for byte-addressed IM.
// Optional power-on clear via IM_BOOT_CLEAR_EN.  Rev 1.0
// =====================================================================
`default_nettype none

module im_boot_ctrl #(
  parameter int MEM_SIZE = 128,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          loadValid,
  input  logic [7:0]    loadByte,
  input  logic          loadLast,
  output logic          loadReady,
  input  logic          reloadIn,
  input  logic [AW-1:0] fetchAddrIn,
  output logic [AW-1:0] imAddrOut,
  output logic          imWrEnOut,
  output logic [7:0]    imWrDataOut,
  output logic          cpuRstOut,
  output logic          bootDoneOut,
  output logic          errOut
);

  localparam int CW = $clog2(MEM_SIZE) + 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    ERR   = 2'd2
`ifdef IM_BOOT_CLEAR_EN
    , CLEAR = 2'd3
`endif
  } state_t;

`ifdef IM_BOOT_CLEAR_EN
  localparam state_t ENTRY = CLEAR;
  localparam int     MW    = $clog2(MEM_SIZE);
  logic [MW-1:0] clr_cnt;
`else
  localparam state_t ENTRY = LOAD;
`endif

  state_t        state;
  state_t        next;
  logic [CW-1:0] byte_cnt;
  logic          transfer;
  logic          fault;
  logic          at_top;

  assign transfer = (state == LOAD) && loadValid && loadReady;
  assign fault    = (fetchAddrIn[1:0] != 2'b00) || (fetchAddrIn > AW'(MEM_SIZE - 4));
  assign at_top   = (byte_cnt == CW'(MEM_SIZE - 1));

  always_comb begin
    next        = state;
    imAddrOut   = '0;
    imWrEnOut   = 1'b0;
    imWrDataOut = 8'h00;
    case (state)
      LOAD: begin
        imAddrOut   = AW'(byte_cnt);
        imWrEnOut   = transfer;
        imWrDataOut = loadByte;
        if (transfer) begin
          // byte_cnt[1:0]==3 means byte_cnt+1 is a whole number of words
          if (loadLast)
            next = (byte_cnt[1:0] == 2'b11) ? RUN : ERR;
          else if (at_top)
            next = ERR;
        end
      end
      RUN: begin
        imAddrOut = fetchAddrIn;
        if (fault)
          next = ERR;
        else if (reloadIn)
          next = ENTRY;
      end
      ERR: next = ERR;
`ifdef IM_BOOT_CLEAR_EN
      CLEAR: begin
        imAddrOut = AW'(clr_cnt);
        imWrEnOut = !rst;
        if (clr_cnt == MW'(MEM_SIZE - 1))
          next = LOAD;
      end
`endif
      default: next = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ENTRY;
      byte_cnt    <= '0;
      loadReady   <= 1'b0;
      cpuRstOut   <= 1'b1;
      bootDoneOut <= 1'b0;
      errOut      <= 1'b0;
    end else begin
      state       <= next;
      loadReady   <= (next == LOAD);
      cpuRstOut   <= (next != RUN);
      bootDoneOut <= (next == RUN);
      errOut      <= (next == ERR);
      if (next == LOAD && state != LOAD)
        byte_cnt <= '0;
      else if (transfer)
        byte_cnt <= byte_cnt + CW'(1);
    end
  end

`ifdef IM_BOOT_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      clr_cnt <= '0;
    else if (state == CLEAR)
      clr_cnt <= clr_cnt + MW'(1);
    else
      clr_cnt <= '0;
  end
`endif

endmodule

`default_nettype wire
